// File: rtl/ysyx_24100012_idu_pkg.sv
// Shared definitions for the pipelined RV32I(+M) decode stage: opcodes,
// writeback/pc-type encodings, the decoded control bundle and occupancy states.
package ysyx_24100012_idu_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   localparam logic [6:0] F7_MEXT  = 7'b0000001;

   localparam logic [1:0] WB_ALU   = 2'b00;
   localparam logic [1:0] WB_PC    = 2'b01;
   localparam logic [1:0] WB_LOAD  = 2'b10;
   localparam logic [1:0] WB_NONE  = 2'b11;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_JUMP   = 2'b01;
   localparam logic [1:0] PC_BRANCH = 2'b10;

   // Everything decoded except pc and imm, whose width follows DATA_WIDTH.
   typedef struct packed {
      logic       illegal;
      logic [2:0] func3;
      logic [4:0] alusel;
      logic [1:0] pctype;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       asel;
      logic       bsel;
      logic       wen;
      logic       memwen;
      logic       memren;
      logic [1:0] wbsel;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // A stored bundle is packed as {pc, imm, ctrl}, ctrl in the low bits.
   function automatic int bundle_w(input int dw);
      return 2 * dw + CTRL_W;
   endfunction

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/ysyx_24100012_idu_comb.sv
// Purely combinational RV32I(+M) decode of one instruction word into the
// control bundle and immediate; illegal encodings yield a trap-only bundle.
module ysyx_24100012_idu_comb
   import ysyx_24100012_idu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int HAS_M      = 1,
   parameter int HAS_SYS    = 1
) (
   input  logic [31:0]           inst,
   output ctrl_t                 ctrl,
   output logic [DATA_WIDTH-1:0] imm
);

   logic [6:0]            opcode;
   logic [2:0]            f3;
   logic                  is_mext;
   logic                  is_shift;
   logic [DATA_WIDTH-1:0] imm_i;
   logic [DATA_WIDTH-1:0] imm_sh;
   logic [DATA_WIDTH-1:0] imm_s;
   logic [DATA_WIDTH-1:0] imm_b;
   logic [DATA_WIDTH-1:0] imm_j;
   logic [DATA_WIDTH-1:0] imm_u;

   assign opcode   = inst[6:0];
   assign f3       = inst[14:12];
   assign is_mext  = (inst[31:25] == F7_MEXT);
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

   assign imm_i  = {{(DATA_WIDTH-11){inst[31]}}, inst[30:20]};
   assign imm_sh = {{(DATA_WIDTH-5){1'b0}}, inst[24:20]};
   assign imm_s  = {{(DATA_WIDTH-11){inst[31]}}, inst[30:25], inst[11:7]};
   assign imm_b  = {{(DATA_WIDTH-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_j  = {{(DATA_WIDTH-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_u  = {{(DATA_WIDTH-31){inst[31]}}, inst[30:12], 12'b0};

   // Default is the illegal bundle; each legal opcode overrides what it uses.
   always_comb begin
      ctrl         = '0;
      ctrl.func3   = f3;
      ctrl.pctype  = PC_SEQ;
      ctrl.wbsel   = WB_NONE;
      ctrl.illegal = 1'b1;
      imm          = '0;
      case (opcode)
         OP_R: begin
            if (!is_mext || (HAS_M != 0)) begin
               ctrl.illegal = 1'b0;
               ctrl.rs1     = inst[19:15];
               ctrl.rs2     = inst[24:20];
               ctrl.rd      = inst[11:7];
               ctrl.wen     = 1'b1;
               ctrl.wbsel   = WB_ALU;
               ctrl.alusel  = is_mext ? {2'b10, f3} : {1'b0, inst[30], f3};
            end
         end
         OP_I: begin
            ctrl.illegal = 1'b0;
            ctrl.rs1     = inst[19:15];
            ctrl.rd      = inst[11:7];
            ctrl.wen     = 1'b1;
            ctrl.bsel    = 1'b1;
            ctrl.wbsel   = WB_ALU;
            ctrl.alusel  = is_shift ? {1'b0, inst[30], f3} : {2'b00, f3};
            imm          = is_shift ? imm_sh : imm_i;
         end
         OP_B: begin
            ctrl.illegal = 1'b0;
            ctrl.rs1     = inst[19:15];
            ctrl.rs2     = inst[24:20];
            ctrl.asel    = 1'b1;
            ctrl.bsel    = 1'b1;
            ctrl.wbsel   = WB_ALU;
            ctrl.pctype  = PC_BRANCH;
            imm          = imm_b;
         end
         OP_L: begin
            ctrl.illegal = 1'b0;
            ctrl.rs1     = inst[19:15];
            ctrl.rd      = inst[11:7];
            ctrl.wen     = 1'b1;
            ctrl.bsel    = 1'b1;
            ctrl.wbsel   = WB_LOAD;
            ctrl.memren  = 1'b1;
            imm          = imm_i;
         end
         OP_S: begin
            ctrl.illegal = 1'b0;
            ctrl.rs1     = inst[19:15];
            ctrl.rs2     = inst[24:20];
            ctrl.bsel    = 1'b1;
            ctrl.memwen  = 1'b1;
            imm          = imm_s;
         end
         OP_JAL: begin
            ctrl.illegal = 1'b0;
            ctrl.rd      = inst[11:7];
            ctrl.wen     = 1'b1;
            ctrl.asel    = 1'b1;
            ctrl.bsel    = 1'b1;
            ctrl.wbsel   = WB_PC;
            ctrl.pctype  = PC_JUMP;
            imm          = imm_j;
         end
         OP_JALR: begin
            ctrl.illegal = 1'b0;
            ctrl.rs1     = inst[19:15];
            ctrl.rd      = inst[11:7];
            ctrl.wen     = 1'b1;
            ctrl.wbsel   = WB_PC;
            ctrl.pctype  = PC_JUMP;
            imm          = imm_i;
         end
         OP_AUIPC: begin
            ctrl.illegal = 1'b0;
            ctrl.rd      = inst[11:7];
            ctrl.wen     = 1'b1;
            ctrl.asel    = 1'b1;
            ctrl.bsel    = 1'b1;
            ctrl.wbsel   = WB_ALU;
            imm          = imm_u;
         end
         OP_LUI: begin
            ctrl.illegal = 1'b0;
            ctrl.rd      = inst[11:7];
            ctrl.wen     = 1'b1;
            ctrl.bsel    = 1'b1;
            ctrl.wbsel   = WB_ALU;
            imm          = imm_u;
         end
         OP_SYS: begin
            if (HAS_SYS != 0) begin
               ctrl.illegal = 1'b0;
               ctrl.rs1     = inst[19:15];
               ctrl.bsel    = 1'b1;
               imm          = imm_i;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_24100012_idu_pipe.sv
// Registered decode stage: decodes at the input, holds up to two decoded
// bundles in a skid queue (head drives the outputs), supports flush.
module ysyx_24100012_idu_pipe
   import ysyx_24100012_idu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int HAS_M      = 1,
   parameter int HAS_SYS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_inst,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_imm,
   output logic [2:0]            out_func3,
   output logic [4:0]            out_alusel,
   output logic [1:0]            out_pctype,
   output logic [4:0]            out_rs1,
   output logic [4:0]            out_rs2,
   output logic [4:0]            out_rd,
   output logic                  out_asel,
   output logic                  out_bsel,
   output logic                  out_wen,
   output logic                  out_memwen,
   output logic                  out_memren,
   output logic [1:0]            out_wbsel,
   output logic                  out_illegal,
   output logic [31:0]           decode_cnt,
   output logic [1:0]            dbg_state
);

   localparam int BW = bundle_w(DATA_WIDTH);

   // Handshake: a transfer happens on a cycle where valid and ready are both
   // high at the rising edge; in_ready/out_valid depend only on occupancy.
   occ_t                  state;
   occ_t                  state_nxt;
   ctrl_t                 dec_ctrl;
   ctrl_t                 head_ctrl;
   logic [DATA_WIDTH-1:0] dec_imm;
   logic [BW-1:0]         in_bundle;
   logic [BW-1:0]         ent_q [2];
   logic                  accept;
   logic                  drain;

   ysyx_24100012_idu_comb #(
      .DATA_WIDTH (DATA_WIDTH),
      .HAS_M      (HAS_M),
      .HAS_SYS    (HAS_SYS)
   ) u_comb (
      .inst (in_inst),
      .ctrl (dec_ctrl),
      .imm  (dec_imm)
   );

   assign in_bundle = {in_pc, dec_imm, dec_ctrl};
   assign in_ready  = (state != ST_TWO);
   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;
   assign dbg_state = state;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (accept) state_nxt = ST_ONE;
         ST_ONE: begin
            if (accept && !drain)      state_nxt = ST_TWO;
            else if (!accept && drain) state_nxt = ST_EMPTY;
         end
         ST_TWO:   if (drain) state_nxt = ST_ONE;
         default:  state_nxt = ST_EMPTY;
      endcase
      if (flush) state_nxt = ST_EMPTY;
   end

   // Entry 0 is always the head; a drain from TWO shifts entry 1 forward.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_EMPTY;
         ent_q[0]   <= '0;
         ent_q[1]   <= '0;
         decode_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (drain) decode_cnt <= decode_cnt + 32'd1;
         if (!flush) begin
            case (state)
               ST_EMPTY: if (accept) ent_q[0] <= in_bundle;
               ST_ONE: begin
                  if (accept && drain) ent_q[0] <= in_bundle;
                  else if (accept)     ent_q[1] <= in_bundle;
               end
               ST_TWO:   if (drain) ent_q[0] <= ent_q[1];
               default: ;
            endcase
         end
      end
   end

   assign {out_pc, out_imm, head_ctrl} = ent_q[0];

   assign out_func3   = head_ctrl.func3;
   assign out_alusel  = head_ctrl.alusel;
   assign out_pctype  = head_ctrl.pctype;
   assign out_rs1     = head_ctrl.rs1;
   assign out_rs2     = head_ctrl.rs2;
   assign out_rd      = head_ctrl.rd;
   assign out_asel    = head_ctrl.asel;
   assign out_bsel    = head_ctrl.bsel;
   assign out_wen     = head_ctrl.wen;
   assign out_memwen  = head_ctrl.memwen;
   assign out_memren  = head_ctrl.memren;
   assign out_wbsel   = head_ctrl.wbsel;
   assign out_illegal = head_ctrl.illegal;

endmodule

// File: tb/tb_ysyx_24100012_idu_pipe.sv
// Bench for the pipelined decoder: directed scenarios plus random traffic
// against a queue-based behavioural model of the decode stage.
module tb_ysyx_24100012_idu_pipe;

   localparam int BW = 97;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_imm, decode_cnt;
   logic [2:0]  out_func3;
   logic [4:0]  out_alusel, out_rs1, out_rs2, out_rd;
   logic [1:0]  out_pctype, out_wbsel, dbg_state;
   logic        out_asel, out_bsel, out_wen, out_memwen, out_memren, out_illegal;

   logic        nm_in_ready, nm_out_valid;
   logic [31:0] nm_out_pc, nm_out_imm, nm_decode_cnt;
   logic [2:0]  nm_out_func3;
   logic [4:0]  nm_out_alusel, nm_out_rs1, nm_out_rs2, nm_out_rd;
   logic [1:0]  nm_out_pctype, nm_out_wbsel, nm_dbg_state;
   logic        nm_out_asel, nm_out_bsel, nm_out_wen, nm_out_memwen, nm_out_memren, nm_out_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   logic [BW-1:0] exp_q[$];
   logic [31:0]   model_cnt = '0;
   logic          chk_en = 1'b0;

   ysyx_24100012_idu_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm), .out_func3(out_func3),
      .out_alusel(out_alusel), .out_pctype(out_pctype),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_asel(out_asel), .out_bsel(out_bsel), .out_wen(out_wen),
      .out_memwen(out_memwen), .out_memren(out_memren),
      .out_wbsel(out_wbsel), .out_illegal(out_illegal),
      .decode_cnt(decode_cnt), .dbg_state(dbg_state)
   );

   ysyx_24100012_idu_pipe #(.DATA_WIDTH(32), .HAS_M(0), .HAS_SYS(0)) dut_nm (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .out_valid(nm_out_valid), .out_ready(out_ready),
      .out_pc(nm_out_pc), .out_imm(nm_out_imm), .out_func3(nm_out_func3),
      .out_alusel(nm_out_alusel), .out_pctype(nm_out_pctype),
      .out_rs1(nm_out_rs1), .out_rs2(nm_out_rs2), .out_rd(nm_out_rd),
      .out_asel(nm_out_asel), .out_bsel(nm_out_bsel), .out_wen(nm_out_wen),
      .out_memwen(nm_out_memwen), .out_memren(nm_out_memren),
      .out_wbsel(nm_out_wbsel), .out_illegal(nm_out_illegal),
      .decode_cnt(nm_decode_cnt), .dbg_state(nm_dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   localparam int K_R = 0, K_I = 1, K_B = 2, K_L = 3, K_S = 4, K_JAL = 5,
                  K_JALR = 6, K_AUIPC = 7, K_LUI = 8, K_SYS = 9, K_ILL = 10;

   // Reference decode from the instruction-class rules: pick the class, then
   // look up control tuple, register usage and immediate format for it.
   function automatic logic [BW-1:0] model_decode(input logic [31:0] inst, input logic [31:0] pc,
                                                  input bit has_m, input bit has_sys);
      int k;
      logic [4:0] ctl;
      logic [31:0] imm;
      logic [4:0] alu, rs1, rs2, rd;
      logic [1:0] pct;
      logic [2:0] f3;
      logic mext, shift;
      f3    = inst[14:12];
      mext  = (inst[31:25] == 7'b0000001);
      shift = (f3 == 3'd1) || (f3 == 3'd5);
      case (inst[6:0])
         7'h33: k = (mext && !has_m) ? K_ILL : K_R;
         7'h13: k = K_I;
         7'h63: k = K_B;
         7'h03: k = K_L;
         7'h23: k = K_S;
         7'h6f: k = K_JAL;
         7'h67: k = K_JALR;
         7'h17: k = K_AUIPC;
         7'h37: k = K_LUI;
         7'h73: k = has_sys ? K_SYS : K_ILL;
         default: k = K_ILL;
      endcase
      case (k)
         K_R:     ctl = 5'b10000;
         K_I:     ctl = 5'b10100;
         K_B:     ctl = 5'b01100;
         K_L:     ctl = 5'b10110;
         K_S:     ctl = 5'b00111;
         K_JAL:   ctl = 5'b11101;
         K_JALR:  ctl = 5'b10001;
         K_AUIPC: ctl = 5'b11100;
         K_LUI:   ctl = 5'b10100;
         K_SYS:   ctl = 5'b00111;
         default: ctl = 5'b00011;
      endcase
      rd  = (k inside {K_R, K_I, K_L, K_JAL, K_JALR, K_AUIPC, K_LUI}) ? inst[11:7] : 5'd0;
      rs1 = (k inside {K_R, K_I, K_B, K_L, K_S, K_JALR, K_SYS}) ? inst[19:15] : 5'd0;
      rs2 = (k inside {K_R, K_B, K_S}) ? inst[24:20] : 5'd0;
      case (k)
         K_I:                imm = shift ? 32'(inst[24:20]) : 32'($signed(inst[31:20]));
         K_L, K_JALR, K_SYS: imm = 32'($signed(inst[31:20]));
         K_S:                imm = 32'($signed({inst[31:25], inst[11:7]}));
         K_B:                imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         K_JAL:              imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         K_AUIPC, K_LUI:     imm = {inst[31:12], 12'h000};
         default:            imm = 32'd0;
      endcase
      if (k == K_R)      alu = mext ? {2'b10, f3} : {1'b0, inst[30], f3};
      else if (k == K_I) alu = shift ? {1'b0, inst[30], f3} : {2'b00, f3};
      else               alu = 5'd0;
      pct = (k == K_B) ? 2'b10 : ((k == K_JAL || k == K_JALR) ? 2'b01 : 2'b00);
      return {pc, imm, f3, alu, pct, rs1, rs2, rd, ctl[3], ctl[2], ctl[4],
              (k == K_S), (k == K_L), ctl[1:0], (k == K_ILL)};
   endfunction

   function automatic logic [BW-1:0] dut_bundle();
      return {out_pc, out_imm, out_func3, out_alusel, out_pctype, out_rs1, out_rs2, out_rd,
              out_asel, out_bsel, out_wen, out_memwen, out_memren, out_wbsel, out_illegal};
   endfunction

   // ---------------- scoreboard ----------------
   // At each falling edge: compare outputs with the model, then advance the
   // model by what the coming rising edge will do with the current inputs.
   always @(negedge clk) begin
      logic acc, drn;
      if (chk_en) begin
         check("out_valid", out_valid, exp_q.size() > 0);
         check("in_ready", in_ready, exp_q.size() < 2);
         check("decode_cnt", decode_cnt, model_cnt);
         if (exp_q.size() > 0) check("bundle", dut_bundle(), exp_q[0]);
      end
      if (rst) begin
         exp_q.delete();
         model_cnt = '0;
         chk_en = 1'b1;
      end else begin
         acc = in_valid && (exp_q.size() < 2);
         drn = out_ready && (exp_q.size() > 0);
         if (drn) model_cnt = model_cnt + 32'd1;
         if (flush) exp_q.delete();
         else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(model_decode(in_inst, in_pc, 1'b1, 1'b1));
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic push(input logic [31:0] inst, input logic [31:0] pc);
      logic hs;
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      do begin
         hs = in_ready;
         step();
         guard++;
      end while (!hs && guard < 50);
      if (!hs) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: in_ready never rose for pc %0h", pc);
      end
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [10];
      logic [31:0] w;
      int sel;
      ops = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h17, 7'h37, 7'h73};
      w   = $urandom();
      sel = $urandom_range(0, 10);
      if (sel < 10) w[6:0] = ops[sel];
      if (w[6:0] == 7'h33) begin
         case ($urandom_range(0, 2))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: w[31:25] = 7'h01;
         endcase
      end
      return w;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      step();
      step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_decode_cnt", decode_cnt, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_imm", out_imm, 32'd0);
      check("rst_out_wbsel", out_wbsel, 2'b00);
      rst = 1'b0;

      // addi x1,x2,5
      out_ready = 1'b1;
      push(32'h00510093, 32'h8000_0000);
      check("addi_valid", out_valid, 1'b1);
      check("addi_rs1", out_rs1, 5'd2);
      check("addi_rd", out_rd, 5'd1);
      check("addi_imm", out_imm, 32'd5);
      check("addi_wen", out_wen, 1'b1);
      check("addi_bsel", out_bsel, 1'b1);
      check("addi_alusel", out_alusel, 5'd0);
      check("addi_wbsel", out_wbsel, 2'b00);
      check("addi_pc", out_pc, 32'h8000_0000);

      // srai x5,x6,3
      push(32'h40335293, 32'h8000_0004);
      check("srai_alusel", out_alusel, 5'b01101);
      check("srai_imm", out_imm, 32'd3);
      check("srai_rs1", out_rs1, 5'd6);
      check("srai_rd", out_rd, 5'd5);
      check("srai_rs2", out_rs2, 5'd0);

      // mul x3,x1,x2 with and without M
      push(32'h022081B3, 32'h8000_0008);
      check("mul_alusel", out_alusel, 5'b10000);
      check("mul_rs2", out_rs2, 5'd2);
      check("mul_illegal", out_illegal, 1'b0);
      check("nm_mul_illegal", nm_out_illegal, 1'b1);
      check("nm_mul_wen", nm_out_wen, 1'b0);
      check("nm_mul_wbsel", nm_out_wbsel, 2'b11);
      step();

      // backpressure: two fill the skid, third must wait
      out_ready = 1'b0;
      push(32'h00100093, 32'h100);
      push(32'h00200113, 32'h104);
      in_valid = 1'b1;
      in_inst  = 32'h00300193;
      in_pc    = 32'h108;
      step();
      step();
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_head_pc", out_pc, 32'h100);
      check("bp_out_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      push(32'h00300193, 32'h108);
      check("bp_third_pc", out_pc, 32'h108);
      step();
      check("bp_decode_cnt", decode_cnt, 32'd6);
      check("bp_drained", out_valid, 1'b0);

      // flush while full with an incoming instruction
      out_ready = 1'b0;
      push(32'h00400213, 32'h200);
      push(32'h00500293, 32'h204);
      in_valid = 1'b1;
      in_inst  = 32'h00600313;
      in_pc    = 32'h208;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      check("flush_decode_cnt", decode_cnt, 32'd6);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("flush_stays_empty", out_valid, 1'b0);
      end

      // reset while full
      out_ready = 1'b0;
      push(32'h00700393, 32'h300);
      push(32'h00800413, 32'h304);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_out_valid", out_valid, 1'b0);
      check("mrst_in_ready", in_ready, 1'b1);
      check("mrst_decode_cnt", decode_cnt, 32'd0);
      check("mrst_out_pc", out_pc, 32'd0);
      check("mrst_out_imm", out_imm, 32'd0);
      check("mrst_out_rd", out_rd, 5'd0);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_inst   = rand_inst();
         in_pc     = $urandom() & 32'hFFFF_FFFC;
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_24100012_idu_pipe.md
Name: ysyx_24100012_idu_pipe

Overview:
Parametrised, pipelined successor to the combinational RV32I decoder. It accepts {inst, pc} from IFU over a valid/ready handshake, decodes RV32I plus an optional M extension, and flags illegal encodings. Results are registered with one cycle of latency. A 2-entry skid buffer gives full throughput under backpressure, and a flush input supports redirects. It sits between IFU and EXU/register-file read.

Parameters:
DATA_WIDTH, 32, width of pc and imm
HAS_M, 1, 1 = decode MUL/DIV/REM (funct7=0000001 on opcode 0110011); 0 = those encodings are illegal
HAS_SYS, 1, 1 = ecall/ebreak (opcode 1110011) are legal; 0 = illegal

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IFU has an instruction
in_ready  out  1  IDU can accept (skid entry free)
in_inst  in  32  instruction word
in_pc  in  DATA_WIDTH  pc of in_inst
flush  in  1  drop all held and incoming instructions this cycle
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts bundle
out_pc  out  DATA_WIDTH  pc passthrough
out_imm  out  DATA_WIDTH  decoded immediate
out_func3  out  3  inst[14:12]
out_alusel  out  5  {mext, inst[30], func3}
out_pctype  out  2  00 seq, 01 jal/jalr, 10 branch
out_rs1, out_rs2, out_rd  out  5 each  register indices; 0 when the field is unused
out_asel, out_bsel, out_wen, out_memwen, out_memren  out  1 each  control bits
out_wbsel  out  2  00 ALU, 01 PC, 10 Load, 11 None
out_illegal  out  1  unrecognised opcode or disabled extension
decode_cnt  out  32  count of bundles accepted by EXU

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, in_ready=1, decode_cnt=0, skid empty, all data outputs 0.
- State machine over occupancy:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - TWO: in_ready=0, out_valid=1.
- Transitions:
  - Accept = in_valid&in_ready. Drain = out_valid&out_ready.
  - Accept only: +1. Drain only: -1. Both: occupancy unchanged; the bundle moves head→tail in order.
- Latency: an instruction accepted at cycle N appears on the outputs at N+1 when the pipe was EMPTY.
- Decode happens at the input. Decoded bundles, not raw instructions, are stored.
- Output is driven from the head entry and is stable while out_valid=1 and out_ready=0.
- flush=1: next state EMPTY, and any same-cycle accept is discarded. decode_cnt counts a same-cycle drain. flush has priority below rst.
- Control tuple {wen,asel,bsel,wbsel} by opcode:
  - R 10000
  - I 10100
  - B 01100
  - L 10110
  - S 00111
  - jal 11101
  - jalr 10001
  - auipc 11100
  - lui 10100
  - sys 00111
- memren=1 only for L; memwen=1 only for S.
- Immediates:
  - I: sign-extended; slli/srli/srai use zero-extended inst[24:20].
  - S, B, J, U: standard RISC-V layouts.
  - R: imm 0.
- out_alusel:
  - R base: {0, inst[30], func3}.
  - R with funct7=0000001 and HAS_M=1: {1, 0, func3}.
  - I with func3 001/101: {0, inst[30], func3}; other I: {0, 0, func3}.
  - All other opcodes: 0.
- rs2=0 for I/L/jal/jalr/auipc/lui/sys; rs1=0 for jal/auipc/lui.
- Illegal instruction: out_illegal=1 and all control bits 0 (wen=memwen=memren=0, wbsel=11); the bundle still flows so EXU can trap.
- decode_cnt increments on drain and wraps at 2^32.

Decomposition:
- Package ysyx_24100012_idu_pkg holds:
  - opcode constants (R, I, B, L, S, JAL, JALR, AUIPC, LUI, SYS)
  - WBSel constants
  - PCType constants
  - bundle width/field offsets
- Sub-module ysyx_24100012_idu_comb: purely combinational decode of {inst, pc} → bundle, parameterised by HAS_M/HAS_SYS.
- Top level holds the 2-entry skid, occupancy FSM, flush handling and counter.

Test Plan:
- Reset, then addi x1,x2,5 (0x00510093), out_ready=1 → next cycle out_valid=1, rs1=2, rd=1, imm=5, wen=1, bsel=1, alusel=0, wbsel=00.
- srai x5,x6,3 (0x40335293) → alusel=5'b01101, imm=3, rs1=6, rd=5, rs2=0.
- mul x3,x1,x2 (0x022081B3): HAS_M=1 → alusel=5'b10000, rs2=2, illegal=0. HAS_M=0 → illegal=1, wen=0, wbsel=11.
- Backpressure: send 3 back-to-back instructions with out_ready=0 → in_ready drops after 2, outputs hold the first. Release out_ready → the 3 instructions emerge in order with no loss; decode_cnt=3.
- flush while TWO with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed instructions never appear.
- rst asserted mid-stream in TWO → next cycle EMPTY, decode_cnt=0, all outputs 0.
